// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, SR/Cause field positions,
// exception codes and the interrupt controller state encoding.
package cp0_pkg;

  // CP0 register numbers as seen on a1
  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  // SR field positions
  localparam int SR_IM_HI = 15;
  localparam int SR_IM_LO = 10;
  localparam int SR_EXL   = 1;
  localparam int SR_IE    = 0;

  // Cause field positions
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_EXC_LO = 2;

  // ExcCode written on interrupt entry
  localparam logic [4:0] EXC_INT = 5'd0;

  // Interrupt controller states
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HANDLER = 2'd1,
    ST_DRAIN   = 2'd2
  } cp0_state_t;

  // Assemble the architectural SR view; unimplemented bits read 0
  function automatic logic [31:0] sr_word(input logic [5:0] im,
                                          input logic exl,
                                          input logic ie);
    logic [31:0] w;
    w = 32'h0;
    w[SR_IM_HI:SR_IM_LO] = im;
    w[SR_EXL] = exl;
    w[SR_IE] = ie;
    return w;
  endfunction

  // Assemble the architectural Cause view; unimplemented bits read 0
  function automatic logic [31:0] cause_word(input logic [5:0] ip,
                                             input logic [4:0] exc_code);
    logic [31:0] w;
    w = 32'h0;
    w[CAUSE_IP_HI:CAUSE_IP_LO] = ip;
    w[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc_code;
    return w;
  endfunction

endpackage

// File: rtl/cp0_int_ctrl.sv
// CP0 interrupt controller: SR/Cause/EPC/PRId register file plus the
// RUN/HANDLER/DRAIN interrupt sequencing FSM.
//
// Handshake: there is no valid/ready pair. int_req is a combinational
// one-cycle "taken" strobe; the pipeline must flush and redirect fetch on
// any cycle where it is high, and the CP0 side effects of the interrupt
// land on the same rising edge.
module cp0_int_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID = 32'h2016_1221
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  hwint,
  input  logic        we,
  input  logic [4:0]  a1,
  input  logic [31:0] din,
  input  logic [31:0] intpc,
  input  logic        eret,
  output logic [31:0] dout,
  output logic [29:0] epc,
  output logic        int_req,
  output logic        exl
);

  cp0_state_t state;
  logic [5:0] im;
  logic       ie;
  logic [5:0] ip;
  logic [4:0] exc_code;

  // Qualified events: eret only means something in HANDLER
  logic eret_eff;
  logic sr_wr;
  logic epc_wr;

  // Interrupt take decision and write decode
  always_comb begin
    int_req  = (state == ST_RUN) && ie && !exl && (|(ip & im));
    eret_eff = eret && (state == ST_HANDLER);
    sr_wr    = we && (a1 == REG_SR);
    epc_wr   = we && (a1 == REG_EPC);
  end

  // mfc0 read port, reflects pre-edge register state (no bypass)
  always_comb begin
    dout = 32'h0;
    case (a1)
      REG_SR:    dout = sr_word(im, exl, ie);
      REG_CAUSE: dout = cause_word(ip, exc_code);
      REG_EPC:   dout = {epc, 2'b00};
      REG_PRID:  dout = PRID;
      default:   dout = 32'h0;
    endcase
  end

  // FSM and CP0 register updates; interrupt entry squashes the mtc0
  // because that instruction is being flushed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_RUN;
      im       <= 6'h00;
      ie       <= 1'b0;
      exl      <= 1'b0;
      ip       <= 6'h00;
      exc_code <= 5'd0;
      epc      <= 30'h0;
    end else begin
      ip <= hwint;
      if (int_req) begin
        epc      <= intpc[31:2];
        exl      <= 1'b1;
        exc_code <= EXC_INT;
        state    <= ST_HANDLER;
      end else begin
        if (sr_wr) begin
          im <= din[SR_IM_HI:SR_IM_LO];
          ie <= din[SR_IE];
        end
        if (epc_wr) begin
          epc <= din[31:2];
        end
        // eret owns EXL when both happen together
        if (eret_eff) begin
          exl <= 1'b0;
        end else if (sr_wr) begin
          exl <= din[SR_EXL];
        end
        case (state)
          ST_RUN: begin
            if (sr_wr && !exl && din[SR_EXL]) begin
              state <= ST_HANDLER;
            end
          end
          ST_HANDLER: begin
            if (eret_eff) begin
              state <= ST_DRAIN;
            end else if (sr_wr && exl && !din[SR_EXL]) begin
              state <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            state <= ST_RUN;
          end
          default: begin
            state <= ST_RUN;
          end
        endcase
      end
    end
  end

endmodule
